tinyqv_mem_arbiter: RTL and testbench

// Shares one QSPI memory-controller command port between the CPU instruction-fetch stream and CPU data loads/stores.

---
 rtl/tinyqv_mem_arbiter_if.sv | 27 ++
 rtl/tinyqv_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_tinyqv_mem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tinyqv_mem_arbiter_if.sv
// Command/data port between the memory arbiter and the QSPI controller.
// The arbiter is the master; the controller is the slave.
interface tinyqv_mem_arbiter_if #(
    parameter int unsigned ADDR_BITS = 24
) ();
    logic                 q_cmd_valid;
    logic                 q_cmd_ready;
    logic                 q_cmd_write;
    logic [1:0]           q_cmd_len;
    logic [ADDR_BITS-1:0] q_cmd_addr;
    logic [31:0]          q_wdata;
    logic                 q_pause;
    logic                 q_stop;
    logic [31:0]          q_rdata;
    logic                 q_rvalid;
    logic                 q_done;

    modport master (
        output q_cmd_valid, q_cmd_write, q_cmd_len, q_cmd_addr, q_wdata, q_pause, q_stop,
        input  q_cmd_ready, q_rdata, q_rvalid, q_done
    );

    modport slave (
        input  q_cmd_valid, q_cmd_write, q_cmd_len, q_cmd_addr, q_wdata, q_pause, q_stop,
        output q_cmd_ready, q_rdata, q_rvalid, q_done
    );
endinterface

// File: rtl/tinyqv_mem_arbiter.sv
// Shares the QSPI command port between the instruction-fetch stream and data accesses.
// Data accesses pre-empt a running stream; fetch resumes on the next restart request.
module tinyqv_mem_arbiter #(
    parameter int unsigned ADDR_BITS      = 24,
    parameter int unsigned HOLDOFF_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [ADDR_BITS-1:1] instr_addr,
    input  logic                 instr_fetch_restart,
    input  logic                 instr_fetch_stall,
    output logic                 instr_fetch_started,
    output logic                 instr_fetch_stopped,
    output logic [15:0]          instr_data_in,
    output logic                 instr_ready,
    input  logic [ADDR_BITS-1:0] data_addr,
    input  logic [1:0]           data_read_n,
    input  logic [1:0]           data_write_n,
    input  logic [31:0]          data_out,
    input  logic                 data_continue,
    output logic [31:0]          data_in,
    output logic                 data_ready,
    tinyqv_mem_arbiter_if.master q
);
    localparam int unsigned CntW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle, StScmd, StStream, StStop, StDcmd, StDwait, StHold
    } state_e;

    state_e               state_q;
    logic                 cmd_write_q;
    logic [1:0]           cmd_len_q;
    logic [ADDR_BITS-1:0] cmd_addr_q;
    logic [31:0]          wdata_q;
    logic [31:0]          data_in_q;
    logic [CntW-1:0]      hold_cnt_q;

    logic                 data_req;
    logic                 req_write;
    logic [1:0]           req_len;
    logic                 take_data;
    logic                 load_beat;
    logic [31:0]          load_data;

    // Both fields active is illegal; the write wins.
    assign data_req  = (data_read_n != 2'b11) || (data_write_n != 2'b11);
    assign req_write = (data_write_n != 2'b11);
    assign req_len   = req_write ? data_write_n : data_read_n;

    assign take_data = data_req && ((state_q == StIdle) || (state_q == StHold) ||
                                    ((state_q == StStop) && q.q_done));

    assign load_beat = (state_q == StDwait) && q.q_rvalid && !cmd_write_q;

    always_comb begin
        load_data = q.q_rdata;
        case (cmd_len_q)
            2'b00:   load_data = {24'b0, q.q_rdata[7:0]};
            2'b01:   load_data = {16'b0, q.q_rdata[15:0]};
            default: load_data = q.q_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            cmd_write_q <= 1'b0;
            cmd_len_q   <= 2'b00;
            cmd_addr_q  <= '0;
            wdata_q     <= '0;
            data_in_q   <= '0;
            hold_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (instr_fetch_restart) begin
                        state_q     <= StScmd;
                        cmd_write_q <= 1'b0;
                        cmd_len_q   <= 2'b11;
                        cmd_addr_q  <= {instr_addr, 1'b0};
                    end
                end
                StScmd: begin
                    if (q.q_cmd_ready) state_q <= StStream;
                end
                StStream: begin
                    if (data_req || !instr_fetch_restart) state_q <= StStop;
                end
                StStop: begin
                    if (q.q_done) state_q <= StIdle;
                end
                StDcmd: begin
                    if (q.q_cmd_ready) state_q <= StDwait;
                end
                StDwait: begin
                    if (load_beat) data_in_q <= load_data;
                    if (q.q_done) begin
                        if (data_continue) begin
                            state_q    <= StHold;
                            hold_cnt_q <= CntW'(HOLDOFF_CYCLES - 1);
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StHold: begin
                    if (hold_cnt_q == '0) state_q <= StIdle;
                    else hold_cnt_q <= hold_cnt_q - 1'b1;
                end
                default: state_q <= StIdle;
            endcase

            // A taken data request overrides whatever the state above chose.
            if (take_data) begin
                state_q     <= StDcmd;
                cmd_write_q <= req_write;
                cmd_len_q   <= req_len;
                cmd_addr_q  <= data_addr;
                wdata_q     <= data_out;
                hold_cnt_q  <= '0;
            end
        end
    end

    assign q.q_cmd_valid = (state_q == StScmd) || (state_q == StDcmd);
    assign q.q_cmd_write = cmd_write_q;
    assign q.q_cmd_len   = cmd_len_q;
    assign q.q_cmd_addr  = cmd_addr_q;
    assign q.q_wdata     = wdata_q;
    assign q.q_pause     = (state_q == StStream) && instr_fetch_stall;
    assign q.q_stop      = (state_q == StStop);

    assign instr_fetch_started = (state_q == StScmd) && q.q_cmd_ready;
    assign instr_fetch_stopped = (state_q == StStop) && q.q_done;
    assign instr_ready         = ((state_q == StStream) || (state_q == StStop)) && q.q_rvalid;
    assign instr_data_in       = q.q_rdata[15:0];

    assign data_in    = load_beat ? load_data : data_in_q;
    assign data_ready = (state_q == StDwait) && q.q_done;
endmodule

// File: tb/tb_tinyqv_mem_arbiter.sv
// Scoreboard bench for tinyqv_mem_arbiter: directed stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_tinyqv_mem_arbiter;
    logic        clk;
    logic        rstn;
    logic [23:1] instr_addr;
    logic        instr_fetch_restart;
    logic        instr_fetch_stall;
    logic        instr_fetch_started;
    logic        instr_fetch_stopped;
    logic [15:0] instr_data_in;
    logic        instr_ready;
    logic [23:0] data_addr;
    logic [1:0]  data_read_n;
    logic [1:0]  data_write_n;
    logic [31:0] data_out;
    logic        data_continue;
    logic [31:0] data_in;
    logic        data_ready;

    tinyqv_mem_arbiter_if #(.ADDR_BITS(24)) qif ();

    tinyqv_mem_arbiter #(.ADDR_BITS(24), .HOLDOFF_CYCLES(8)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .instr_addr          (instr_addr),
        .instr_fetch_restart (instr_fetch_restart),
        .instr_fetch_stall   (instr_fetch_stall),
        .instr_fetch_started (instr_fetch_started),
        .instr_fetch_stopped (instr_fetch_stopped),
        .instr_data_in       (instr_data_in),
        .instr_ready         (instr_ready),
        .data_addr           (data_addr),
        .data_read_n         (data_read_n),
        .data_write_n        (data_write_n),
        .data_out            (data_out),
        .data_continue       (data_continue),
        .data_in             (data_in),
        .data_ready          (data_ready),
        .q                   (qif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [58:0] val;
        logic        wcare;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic [15:0] instr_q[$];
    logic [31:0] data_q[$];
    int          stopped_exp = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT event with no expectation queued", name);
    endtask

    task automatic push_cmd(input logic wr, input logic [1:0] len, input logic [23:0] addr,
                            input logic [31:0] wdata, input logic wcare);
        cmd_t c;
        c.val   = {wr, len, addr, wdata};
        c.wcare = wcare;
        cmd_q.push_back(c);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge clk) begin
        if (rstn) begin
            if (qif.q_cmd_valid && qif.q_cmd_ready) begin
                if (cmd_q.size() == 0) begin
                    unexpected("cmd_handshake");
                end else begin
                    cmd_t        e;
                    logic [58:0] mask;
                    e    = cmd_q.pop_front();
                    mask = e.wcare ? {59{1'b1}} : {{27{1'b1}}, 32'h0};
                    check("cmd_fields",
                          {5'h0, {qif.q_cmd_write, qif.q_cmd_len, qif.q_cmd_addr,
                                  qif.q_wdata} & mask},
                          {5'h0, e.val & mask});
                end
                check("started_on_handshake", {63'h0, instr_fetch_started},
                      {63'h0, qif.q_cmd_len == 2'b11});
            end else if (instr_fetch_started) begin
                check("started_spurious", {63'h0, instr_fetch_started}, 64'h0);
            end
            if (instr_ready) begin
                if (instr_q.size() == 0) unexpected("instr_ready");
                else check("instr_beat", {48'h0, instr_data_in}, {48'h0, instr_q.pop_front()});
            end
            if (data_ready) begin
                if (data_q.size() == 0) unexpected("data_ready");
                else check("data_in", {32'h0, data_in}, {32'h0, data_q.pop_front()});
            end
            if (instr_fetch_stopped) begin
                if (stopped_exp == 0) unexpected("fetch_stopped");
                else begin
                    n_checks++;
                    stopped_exp--;
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] beats [3];
        beats[0] = 16'h1111;
        beats[1] = 16'h2222;
        beats[2] = 16'h3333;

        rstn = 1'b0;
        instr_addr = 23'h000100;
        instr_fetch_restart = 1'b1;
        instr_fetch_stall = 1'b0;
        data_addr = '0;
        data_read_n = 2'b11;
        data_write_n = 2'b11;
        data_out = '0;
        data_continue = 1'b0;
        qif.q_cmd_ready = 1'b0;
        qif.q_rdata = '0;
        qif.q_rvalid = 1'b0;
        qif.q_done = 1'b0;

        // Reset held with restart requested.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_outputs", {12'h0, instr_fetch_started, instr_fetch_stopped, instr_data_in,
                                  instr_ready, data_in, data_ready}, 64'h0);
        check("rst_q_outputs", {2'h0, qif.q_cmd_valid, qif.q_cmd_write, qif.q_cmd_len,
                                qif.q_cmd_addr, qif.q_wdata, qif.q_pause, qif.q_stop}, 64'h0);
        tick;
        rstn = 1'b1;
        @(negedge clk);
        check("first_cycle_quiet", {59'h0, qif.q_cmd_valid, instr_fetch_started,
                                    instr_fetch_stopped, instr_ready, data_ready}, 64'h0);

        // Stream command.
        push_cmd(1'b0, 2'b11, 24'h000200, 32'h0, 1'b0);
        tick;
        @(negedge clk);
        check("scmd_valid_len", {61'h0, qif.q_cmd_valid, qif.q_cmd_len}, {61'h0, 1'b1, 2'b11});
        check("scmd_addr", {40'h0, qif.q_cmd_addr}, 64'h200);
        tick;
        qif.q_cmd_ready = 1'b1;
        tick;
        qif.q_cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            instr_q.push_back(beats[i]);
            qif.q_rvalid = 1'b1;
            qif.q_rdata = {16'hA5A5, beats[i]};
            tick;
        end
        qif.q_rvalid = 1'b0;
        instr_fetch_stall = 1'b1;
        @(negedge clk);
        check("stall_pause", {63'h0, qif.q_pause}, 64'h1);
        check("stall_no_beat", {63'h0, instr_ready}, 64'h0);

        // Data read pre-empts the stream.
        tick;
        instr_fetch_stall = 1'b0;
        instr_fetch_restart = 1'b0;
        data_read_n = 2'b10;
        data_addr = 24'h001000;
        @(negedge clk);
        check("stop_not_yet", {63'h0, qif.q_stop}, 64'h0);
        tick;
        instr_fetch_stall = 1'b1;
        instr_q.push_back(16'h4444);
        qif.q_rvalid = 1'b1;
        qif.q_rdata = 32'h0000_4444;
        @(negedge clk);
        check("stop_asserted", {62'h0, qif.q_stop, qif.q_pause}, 64'h2);
        tick;
        qif.q_rvalid = 1'b0;
        instr_fetch_stall = 1'b0;
        qif.q_done = 1'b1;
        stopped_exp++;
        push_cmd(1'b0, 2'b10, 24'h001000, 32'h0, 1'b0);
        tick;
        qif.q_done = 1'b0;
        qif.q_cmd_ready = 1'b1;
        tick;
        qif.q_cmd_ready = 1'b0;
        data_q.push_back(32'hDEADBEEF);
        qif.q_rdata = 32'hDEADBEEF;
        qif.q_rvalid = 1'b1;
        qif.q_done = 1'b1;
        tick;
        qif.q_rvalid = 1'b0;
        qif.q_done = 1'b0;
        qif.q_rdata = 32'h0;
        data_read_n = 2'b11;
        @(negedge clk);
        check("data_in_held", {32'h0, data_in}, 64'hDEADBEEF);

        // Byte store with continue; command held while the controller stalls.
        instr_fetch_restart = 1'b1;
        instr_addr = 23'h000180;
        data_write_n = 2'b00;
        data_addr = 24'h002000;
        data_out = 32'h12345678;
        data_continue = 1'b1;
        push_cmd(1'b1, 2'b00, 24'h002000, 32'h12345678, 1'b1);
        tick;
        data_write_n = 2'b11;
        data_addr = 24'h0;
        data_out = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("dcmd_hold_valid", {63'h0, qif.q_cmd_valid}, 64'h1);
            check("dcmd_hold_fields", {5'h0, qif.q_cmd_write, qif.q_cmd_len, qif.q_cmd_addr,
                                       qif.q_wdata}, {5'h0, 1'b1, 2'b00, 24'h002000,
                                       32'h12345678});
            tick;
        end
        qif.q_cmd_ready = 1'b1;
        tick;
        qif.q_cmd_ready = 1'b0;
        data_q.push_back(32'hDEADBEEF);  // a store leaves load data untouched
        qif.q_done = 1'b1;
        tick;
        qif.q_done = 1'b0;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            check("hold_short_idle", {63'h0, qif.q_cmd_valid}, 64'h0);
            tick;
        end
        data_write_n = 2'b00;
        data_addr = 24'h002004;
        data_out = 32'hCAFEF00D;
        push_cmd(1'b1, 2'b00, 24'h002004, 32'hCAFEF00D, 1'b1);
        @(negedge clk);
        check("hold_short_idle", {63'h0, qif.q_cmd_valid}, 64'h0);
        tick;
        data_write_n = 2'b11;
        qif.q_cmd_ready = 1'b1;
        tick;
        qif.q_cmd_ready = 1'b0;
        data_q.push_back(32'hDEADBEEF);
        qif.q_done = 1'b1;
        tick;
        qif.q_done = 1'b0;

        // Long gap: holdoff expires, then the pending restart is served.
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            check("hold_long_quiet", {63'h0, qif.q_cmd_valid}, 64'h0);
            tick;
        end
        push_cmd(1'b0, 2'b11, 24'h000300, 32'h0, 1'b0);
        qif.q_cmd_ready = 1'b1;
        @(negedge clk);
        check("restart_after_hold", {61'h0, qif.q_cmd_valid, qif.q_cmd_len}, {61'h0, 1'b1, 2'b11});
        tick;
        qif.q_cmd_ready = 1'b0;
        instr_fetch_restart = 1'b0;
        tick;
        qif.q_done = 1'b1;
        stopped_exp++;
        tick;
        qif.q_done = 1'b0;

        // Byte load, then asynchronous reset while waiting for completion.
        data_read_n = 2'b00;
        data_addr = 24'h003001;
        push_cmd(1'b0, 2'b00, 24'h003001, 32'h0, 1'b0);
        tick;
        qif.q_cmd_ready = 1'b1;
        tick;
        qif.q_cmd_ready = 1'b0;
        qif.q_rvalid = 1'b1;
        qif.q_rdata = 32'hAABBCCDD;
        @(negedge clk);
        check("load_len1_pass", {32'h0, data_in}, 64'hDD);
        tick;
        qif.q_rvalid = 1'b0;
        qif.q_rdata = 32'h0;
        @(negedge clk);
        check("load_len1_latched", {32'h0, data_in}, 64'hDD);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_q", {29'h0, qif.q_cmd_valid, qif.q_cmd_write, qif.q_cmd_len,
                              qif.q_cmd_addr, qif.q_stop, qif.q_pause, data_ready}, 64'h0);
        check("async_rst_data_in", {32'h0, data_in}, 64'h0);
        data_read_n = 2'b11;
        tick;
        tick;
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {63'h0, qif.q_cmd_valid}, 64'h0);
        tick;
        @(negedge clk);
        check("post_rst_idle", {63'h0, qif.q_cmd_valid}, 64'h0);

        // Halfword load.
        data_read_n = 2'b01;
        data_addr = 24'h004002;
        push_cmd(1'b0, 2'b01, 24'h004002, 32'h0, 1'b0);
        tick;
        qif.q_cmd_ready = 1'b1;
        tick;
        qif.q_cmd_ready = 1'b0;
        data_read_n = 2'b11;
        data_q.push_back(32'h0000_7788);
        qif.q_rdata = 32'h5566_7788;
        qif.q_rvalid = 1'b1;
        qif.q_done = 1'b1;
        tick;
        qif.q_rvalid = 1'b0;
        qif.q_done = 1'b0;
        tick;
        tick;

        check("cmd_q_drained", 64'(cmd_q.size()), 64'h0);
        check("instr_q_drained", 64'(instr_q.size()), 64'h0);
        check("data_q_drained", 64'(data_q.size()), 64'h0);
        check("stopped_drained", 64'(stopped_exp), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
